icache_dm: RTL

ICACHE_DM -- requirements
Module: icache_dm

---
 rtl/icache_dm_pkg.sv | 27 ++
 rtl/icache_array.sv | 72 +++++++
 rtl/icache_dm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// controller state encoding, datapath width and address-field width helpers.
package icache_dm_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MISS_REQ = 2'd1,
        S_REFILL   = 2'd2,
        S_RESPOND  = 2'd3
    } state_e;

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Tag is whatever remains above index, word offset and the 2 byte bits.
    function automatic int tag_bits(input int num_lines, input int words_per_line);
        return XLEN - idx_bits(num_lines) - off_bits(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (valid bits only)
//   rd_waddr_i     word address (byte address >> 2) looked up combinationally
//   rd_hit_o       line valid and tag match for rd_waddr_i
//   rd_data_o      stored word at rd_waddr_i (independent of hit)
//   wr_en_i        write wr_data_i into the word selected by wr_waddr_i
//   wr_waddr_i     word address of the refill write (also supplies tag/index)
//   tag_we_i       write tag of wr_waddr_i and set line valid to tag_valid_i
//   inv_all_i      clear every valid bit; wins over a same-cycle tag write
module icache_array
    import icache_dm_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-3:0] rd_waddr_i,
    output logic            rd_hit_o,
    output logic [XLEN-1:0] rd_data_o,
    input  logic            wr_en_i,
    input  logic [XLEN-3:0] wr_waddr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            tag_we_i,
    input  logic            tag_valid_i,
    input  logic            inv_all_i
);

    localparam int IDX_W = idx_bits(NUM_LINES);
    localparam int OFF_W = off_bits(WORDS_PER_LINE);
    localparam int TAG_W = tag_bits(NUM_LINES, WORDS_PER_LINE);
    localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;

    logic [XLEN-1:0]      data_q [DEPTH];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    logic [IDX_W-1:0] rd_line;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_line;
    logic [TAG_W-1:0] wr_tag;

    assign rd_line = rd_waddr_i[OFF_W +: IDX_W];
    assign rd_tag  = rd_waddr_i[XLEN-3 -: TAG_W];
    assign wr_line = wr_waddr_i[OFF_W +: IDX_W];
    assign wr_tag  = wr_waddr_i[XLEN-3 -: TAG_W];

    assign rd_hit_o  = valid_q[rd_line] && (tag_q[rd_line] == rd_tag);
    assign rd_data_o = data_q[rd_waddr_i[IDX_W+OFF_W-1:0]];

    // Data and tags carry no reset; only the valid bits define contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_waddr_i[IDX_W+OFF_W-1:0]] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_line] <= wr_tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_line] <= tag_valid_i;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with line refill from memory.
// Ports:
//   clock_i, reset_i          clock, async active-high reset
//   req_valid_i/req_addr_i    fetch request (byte address, bits [1:0] ignored)
//   req_ready_o               request accepted this cycle (IDLE only)
//   resp_valid_o/resp_instr_o fetched instruction, one cycle after acceptance
//                             on a hit, one cycle after RESPOND on a miss
//   flush_i                   invalidate all lines
//   mem_req_*                 line-aligned refill request handshake
//   mem_resp_valid_i/data_i   refill beats in ascending word order
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | accepting fetches; hits answered next cycle
// S_MISS_REQ | refill request held on mem_req_* until accepted
// S_REFILL   | writing incoming beats into the line at beat_q
// S_RESPOND  | line complete; requested word read and presented next cycle
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    input  logic [XLEN-1:0] req_addr_i,
    output logic            req_ready_o,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_instr_o,
    input  logic            flush_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_resp_valid_i,
    input  logic [XLEN-1:0] mem_resp_data_i
);

    localparam int              OFF_W     = off_bits(WORDS_PER_LINE);
    localparam logic [XLEN-1:0] LINE_MASK = ~(XLEN'(WORDS_PER_LINE * 4 - 1));

    state_e            state_q;
    logic [XLEN-3:0]   addr_q;
    logic [OFF_W-1:0]  beat_q;
    logic              flush_pend_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_instr_q;
    logic              mem_req_valid_q;
    logic [XLEN-1:0]   mem_req_addr_q;

    logic [XLEN-3:0]   lookup_waddr;
    logic              rd_hit;
    logic [XLEN-1:0]   rd_data;
    logic              beat_we;
    logic              last_beat;

    // In IDLE the array looks at the incoming request; otherwise it points at
    // the captured miss address so RESPOND can read back the requested word.
    assign lookup_waddr = (state_q == S_IDLE) ? req_addr_i[XLEN-1:2] : addr_q;

    assign beat_we   = (state_q == S_REFILL) && mem_resp_valid_i;
    assign last_beat = beat_we && (beat_q == OFF_W'(WORDS_PER_LINE - 1));

    icache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk_i       (clock_i),
        .rst_i       (reset_i),
        .rd_waddr_i  (lookup_waddr),
        .rd_hit_o    (rd_hit),
        .rd_data_o   (rd_data),
        .wr_en_i     (beat_we),
        .wr_waddr_i  ({addr_q[XLEN-3:OFF_W], beat_q}),
        .wr_data_i   (mem_resp_data_i),
        .tag_we_i    (last_beat),
        // A flush seen at any point during this miss leaves the line invalid.
        .tag_valid_i (!(flush_pend_q || flush_i)),
        .inv_all_i   (flush_i)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            flush_pend_q    <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_instr_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        // A same-cycle flush turns a would-be hit into a miss.
                        if (rd_hit && !flush_i) begin
                            resp_valid_q <= 1'b1;
                            resp_instr_q <= rd_data;
                        end else begin
                            addr_q          <= req_addr_i[XLEN-1:2];
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= req_addr_i & LINE_MASK;
                            state_q         <= S_MISS_REQ;
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (last_beat) begin
                        beat_q       <= '0;
                        flush_pend_q <= 1'b0;
                        state_q      <= S_RESPOND;
                    end else if (beat_we) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                S_RESPOND: begin
                    resp_valid_q <= 1'b1;
                    resp_instr_q <= rd_data;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign resp_valid_o    = resp_valid_q;
    assign resp_instr_o    = resp_instr_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;

endmodule
